// File: rtl/uart_frame_parser.sv
// Frame parser behind the uart RX FIFO: SOF, LEN, payload, CHK, then hold for the host.
// Define FRAME_TIMEOUT_EN to add the inter-byte timeout (err_code 11).
module uart_frame_parser #(
    parameter int unsigned          DATA_BITS      = 8,
    parameter int unsigned          MAX_LEN        = 16,
    parameter logic [DATA_BITS-1:0] SOF            = 8'h7E,
    parameter int unsigned          TIMEOUT_CYCLES = 65535,
    localparam int unsigned         AW             = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_ready,
    output logic                 rx,
    input  logic [DATA_BITS-1:0] rx_data,
    output logic                 frm_valid,
    output logic [7:0]           frm_len,
    input  logic [AW-1:0]        frm_addr,
    output logic [DATA_BITS-1:0] frm_data,
    input  logic                 frm_ack,
    output logic                 err,
    output logic [1:0]           err_code
);

    typedef enum logic [2:0] {StIdle, StLen, StPay, StChk, StHold} state_e;

    state_e               state_q, state_d;
    logic                 rx_q, rx_d;
    logic [7:0]           len_q, len_d;
    logic [DATA_BITS-1:0] sum_q, sum_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic [1:0]           code_q, code_d;
    logic                 buf_we;
    logic                 len_ok;
    logic                 tmo_hit;
    logic [DATA_BITS-1:0] buf_mem [MAX_LEN];

`ifdef FRAME_TIMEOUT_EN
    logic [15:0] tmo_q, tmo_d;

    // Counts only stalled cycles mid-frame; any pop or leaving the frame states clears it.
    always_comb begin
        tmo_d   = '0;
        tmo_hit = 1'b0;
        if (!rx_q && (state_q == StLen || state_q == StPay || state_q == StChk)) begin
            if (tmo_q == 16'(TIMEOUT_CYCLES - 1)) begin
                tmo_hit = 1'b1;
            end else begin
                tmo_d = tmo_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign len_ok = (rx_data != '0) && (32'(rx_data) <= MAX_LEN);

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        code_d  = code_q;
        buf_we  = 1'b0;
        // Registered pop: never back to back, and never in the cycle HOLD is left.
        rx_d    = rx_ready && !rx_q && (state_q != StHold);
        unique case (state_q)
            StIdle: begin
                if (rx_q && rx_data == SOF) state_d = StLen;
            end
            StLen: begin
                if (rx_q) begin
                    if (!len_ok) begin
                        err_d   = 1'b1;
                        code_d  = 2'b01;
                        state_d = StIdle;
                    end else begin
                        len_d   = 8'(rx_data);
                        sum_d   = rx_data;
                        cnt_d   = '0;
                        state_d = StPay;
                    end
                end
            end
            StPay: begin
                if (rx_q) begin
                    buf_we = 1'b1;
                    sum_d  = sum_q + rx_data;
                    cnt_d  = cnt_q + 8'd1;
                    if (cnt_q == len_q - 8'd1) state_d = StChk;
                end
            end
            StChk: begin
                if (rx_q) begin
                    if (rx_data == sum_q) begin
                        state_d = StHold;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = 2'b10;
                        state_d = StIdle;
                    end
                end
            end
            StHold: begin
                if (frm_ack) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (tmo_hit) begin
            err_d   = 1'b1;
            code_d  = 2'b11;
            state_d = StIdle;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            rx_q    <= 1'b0;
            len_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            code_q  <= '0;
        end else begin
            state_q <= state_d;
            rx_q    <= rx_d;
            len_q   <= len_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) buf_mem[cnt_q[AW-1:0]] <= rx_data;
    end

    assign rx        = rx_q;
    assign frm_valid = (state_q == StHold);
    assign frm_len   = len_q;
    assign frm_data  = buf_mem[frm_addr];
    assign err       = err_q;
    assign err_code  = code_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser with a queue standing in for the uart RX FIFO.
// Build with FRAME_TIMEOUT_EN defined to exercise the timeout path.
module tb_uart_frame_parser;

    localparam int TMO = 50;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_ready = 1'b0;
    logic       rx;
    logic [7:0] rx_data = '0;
    logic       frm_valid;
    logic [7:0] frm_len;
    logic [3:0] frm_addr = '0;
    logic [7:0] frm_data;
    logic       frm_ack = 1'b0;
    logic       err;
    logic [1:0] err_code;

    uart_frame_parser #(
        .DATA_BITS      (8),
        .MAX_LEN        (16),
        .SOF            (8'h7E),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_ready  (rx_ready),
        .rx        (rx),
        .rx_data   (rx_data),
        .frm_valid (frm_valid),
        .frm_len   (frm_len),
        .frm_addr  (frm_addr),
        .frm_data  (frm_data),
        .frm_ack   (frm_ack),
        .err       (err),
        .err_code  (err_code)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] q[$];
    bit  pending = 0;
    int  cyc = 0, last_pop_cyc = 0, fall_cyc = 0, pops = 0;
    int  valid_lat = -1, err_lat = -1, err_cnt = 0;
    int  rx_viol = 0, err_viol = 0;
    bit  prev_rx = 0, prev_valid = 0, prev_err = 0;

    // FIFO model and protocol monitor; a pop takes effect on the negedge after the rx cycle.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (pending) begin
                void'(q.pop_front());
                pending = 0;
            end
            if (rx) begin
                if (prev_rx || !rx_ready || frm_valid || cyc <= fall_cyc) rx_viol++;
                pending      = 1;
                last_pop_cyc = cyc;
                pops++;
            end
            if (frm_valid && !prev_valid) valid_lat = cyc - last_pop_cyc;
            if (!frm_valid && prev_valid) fall_cyc = cyc;
            if (err) begin
                if (prev_err) begin
                    err_viol++;
                end else begin
                    err_cnt++;
                    err_lat = cyc - last_pop_cyc;
                end
            end
            prev_rx    = rx;
            prev_valid = frm_valid;
            prev_err   = err;
            rx_ready   = (q.size() != 0);
            rx_data    = rx_ready ? q[0] : 8'h00;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic push_n(input logic [63:0] bytes, input int n);
        for (int i = 0; i < n; i++) q.push_back(bytes[8*(n-1-i) +: 8]);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            tick(1);
            ok = frm_valid;
        end
    endtask

    task automatic wait_err(input int base, output bit ok);
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            tick(1);
            ok = (err_cnt > base);
        end
    endtask

    task automatic drain(output bit ok);
        ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            tick(1);
            ok = (q.size() == 0) && !pending;
        end
    endtask

    task automatic ack(input string tag);
        frm_ack = 1'b1;
        tick(1);
        frm_ack = 1'b0;
        check(tag, frm_valid, 1'b0);
    endtask

    task automatic read_byte(input string tag, input int addr, input logic [7:0] exp);
        frm_addr = 4'(addr);
        #1;
        check(tag, frm_data, exp);
    endtask

    bit ok;
    int base, p;

    initial begin
        // Reset values
        tick(3);
        check("rst_rx", rx, 1'b0);
        check("rst_valid", frm_valid, 1'b0);
        check("rst_len", frm_len, 8'd0);
        check("rst_err", err, 1'b0);
        check("rst_code", err_code, 2'b00);
        rst = 1'b0;
        tick(2);

        // Good frame, 3 bytes
        push_n(48'h7E0311223369, 6);
        wait_valid(ok);
        check("good_valid", ok, 1'b1);
        check("good_lat", valid_lat, 1);
        check("good_len", frm_len, 8'd3);
        read_byte("good_d0", 0, 8'h11);
        read_byte("good_d1", 1, 8'h22);
        read_byte("good_d2", 2, 8'h33);
        check("good_noerr", err_cnt, 0);
        ack("good_ack");

        // Bad checksum: expected 67, sent 00
        base = err_cnt;
        push_n(40'h7E02AABB00, 5);
        wait_err(base, ok);
        check("chk_err", ok, 1'b1);
        check("chk_code", err_code, 2'b10);
        check("chk_lat", err_lat, 1);
        tick(3);
        check("chk_novalid", frm_valid, 1'b0);

        // Length 0 and length > MAX_LEN
        base = err_cnt;
        push_n(16'h7E00, 2);
        wait_err(base, ok);
        check("len0_err", ok, 1'b1);
        check("len0_code", err_code, 2'b01);
        base = err_cnt;
        push_n(16'h7E11, 2);
        wait_err(base, ok);
        check("len17_err", ok, 1'b1);
        check("len17_code", err_code, 2'b01);
        push_n(32'h7E015A5B, 4);
        wait_valid(ok);
        check("after_len_valid", ok, 1'b1);
        check("after_len_len", frm_len, 8'd1);
        read_byte("after_len_d0", 0, 8'h5A);
        ack("after_len_ack");

        // Garbage before SOF is dropped silently
        base = err_cnt;
        push_n(64'h0055FF7E02010205, 8);
        wait_valid(ok);
        check("garb_valid", ok, 1'b1);
        check("garb_noerr", err_cnt, base);
        check("garb_len", frm_len, 8'd2);
        read_byte("garb_d1", 1, 8'h02);
        ack("garb_ack");

        // Held frame blocks a queued second frame until ack
        push_n(32'h7E011011, 4);
        push_n(40'h7E02203052, 5);
        wait_valid(ok);
        check("hold_a_valid", ok, 1'b1);
        check("hold_a_len", frm_len, 8'd1);
        read_byte("hold_a_d0", 0, 8'h10);
        p = pops;
        tick(100);
        check("hold_nopop", pops, p);
        check("hold_still_valid", frm_valid, 1'b1);
        check("hold_fifo", q.size(), 5);
        ack("hold_a_ack");
        wait_valid(ok);
        check("hold_b_valid", ok, 1'b1);
        check("hold_b_len", frm_len, 8'd2);
        read_byte("hold_b_d0", 0, 8'h20);
        read_byte("hold_b_d1", 1, 8'h30);
        ack("hold_b_ack");

        // Stall mid-frame
        base = err_cnt;
        push_n(24'h7E0411, 3);
`ifdef FRAME_TIMEOUT_EN
        wait_err(base, ok);
        check("tmo_err", ok, 1'b1);
        check("tmo_code", err_code, 2'b11);
        check("tmo_lat", err_lat, TMO + 1);
        check("tmo_novalid", frm_valid, 1'b0);
`else
        drain(ok);
        check("stall_drain", ok, 1'b1);
        tick(100);
        check("stall_noerr", err_cnt, base);
        check("stall_novalid", frm_valid, 1'b0);
        push_n(32'h223344AE, 4);
        wait_valid(ok);
        check("stall_valid", ok, 1'b1);
        check("stall_len", frm_len, 8'd4);
        read_byte("stall_d3", 3, 8'h44);
        ack("stall_ack");
`endif

        // Reset mid-frame
        push_n(24'h7E02AB, 3);
        drain(ok);
        check("mid_drain", ok, 1'b1);
        tick(2);
        rst = 1'b1;
        tick(1);
        check("mid_rst_rx", rx, 1'b0);
        check("mid_rst_valid", frm_valid, 1'b0);
        check("mid_rst_len", frm_len, 8'd0);
        check("mid_rst_err", err, 1'b0);
        check("mid_rst_code", err_code, 2'b00);
        rst = 1'b0;
        tick(2);
        push_n(32'h7E01999A, 4);
        wait_valid(ok);
        check("post_rst_valid", ok, 1'b1);
        check("post_rst_len", frm_len, 8'd1);
        read_byte("post_rst_d0", 0, 8'h99);
        ack("post_rst_ack");

        tick(5);
        check("rx_protocol", rx_viol, 0);
        check("err_width", err_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
